// File: rtl/cntr_ctrl.sv
// cntr_ctrl: interval-timer sequencer for a 16-bit synchronous counter.
//
// Drives the counter's synchronous clear and count enable, and watches its value.
// Provides a programmable prescaler, a terminal-count limit and one-shot or
// periodic operation. Each run passes through IDLE -> ARM -> RUN.
//
// Parameters
//   PSC_W     width of the prescale field and the internal prescaler counter
//   CNT_W     width of the controlled counter value and the limit field
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   start     begin a run (sampled only in IDLE)
//   stop      abort a run; the counter value is held
//   clr       clear counter and prescaler, legal in any state
//   periodic  0 = one-shot, 1 = auto-restart (latched at start)
//   prescale  cnt_ce every prescale+1 RUN cycles (latched at start)
//   limit     terminal count (latched at start)
//   cnt_val   current value of the controlled counter
//   cnt_clr   synchronous clear to the counter
//   cnt_ce    count enable to the counter
//   busy      high in ARM or RUN
//   done      one-cycle pulse on terminal count
//
// Optional feature, enabled by defining CNTR_CTRL_IRQ_EN:
//   irq_ack   acknowledge, clears irq the following cycle
//   irq       sticky flag, set the cycle after done (set wins over irq_ack)

module cntr_ctrl #(
  parameter int unsigned PSC_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             periodic,
  input  logic [PSC_W-1:0] prescale,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] cnt_val,
`ifdef CNTR_CTRL_IRQ_EN
  input  logic             irq_ack,
  output logic             irq,
`endif
  output logic             cnt_clr,
  output logic             cnt_ce,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PSC_W-1:0] psc_q, psc_d;

  // Run configuration, captured once at start and held for the whole run.
  logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
  logic [CNT_W-1:0] limit_sh_q, limit_sh_d;
  logic             periodic_sh_q, periodic_sh_d;

  logic match;
  logic tick;

  assign match = (cnt_val == limit_sh_q);
  assign tick  = (psc_q == psc_sh_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      psc_q         <= '0;
      psc_sh_q      <= '0;
      limit_sh_q    <= '0;
      periodic_sh_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psc_q         <= psc_d;
      psc_sh_q      <= psc_sh_d;
      limit_sh_q    <= limit_sh_d;
      periodic_sh_q <= periodic_sh_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psc_d         = psc_q;
    psc_sh_d      = psc_sh_q;
    limit_sh_d    = limit_sh_q;
    periodic_sh_d = periodic_sh_q;
    cnt_clr       = 1'b0;
    cnt_ce        = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          cnt_clr = 1'b1;
          psc_d   = '0;
        end
        // stop is not looked at here, so start+stop together still starts a run.
        if (start) begin
          psc_sh_d      = prescale;
          limit_sh_d    = limit;
          periodic_sh_d = periodic;
          state_d       = StArm;
        end
      end

      StArm: begin
        // Clearing the counter here is what lets limit=0 match on the first RUN cycle.
        cnt_clr = 1'b1;
        psc_d   = '0;
        state_d = StRun;
      end

      StRun: begin
        if (stop) begin
          // Abort: counter is left holding its value.
          psc_d   = '0;
          state_d = StIdle;
        end else if (clr) begin
          cnt_clr = 1'b1;
          psc_d   = '0;
        end else if (match) begin
          done    = 1'b1;
          psc_d   = '0;
          state_d = periodic_sh_q ? StArm : StIdle;
        end else if (tick) begin
          cnt_ce = 1'b1;
          psc_d  = '0;
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q == StArm) || (state_q == StRun);

`ifdef CNTR_CTRL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (done) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_cntr_ctrl.sv
// Bench for cntr_ctrl: table-driven cycle vectors plus hand-written sequences.
// A behavioural model of the controlled 16-bit counter closes the loop on cnt_val.
module tb_cntr_ctrl;

  localparam int unsigned PSC_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, clr, periodic;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt_val = '0;
  logic             cnt_clr, cnt_ce, busy, done;
`ifdef CNTR_CTRL_IRQ_EN
  logic             irq_ack;
  logic             irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cntr_ctrl #(
    .PSC_W(PSC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .periodic(periodic),
    .prescale(prescale),
    .limit   (limit),
    .cnt_val (cnt_val),
`ifdef CNTR_CTRL_IRQ_EN
    .irq_ack (irq_ack),
    .irq     (irq),
`endif
    .cnt_clr (cnt_clr),
    .cnt_ce  (cnt_ce),
    .busy    (busy),
    .done    (done)
  );

  // Controlled counter: synchronous clear, count enable, not reset by rst.
  always @(posedge clk) begin
    if (cnt_clr) cnt_val <= '0;
    else if (cnt_ce) cnt_val <= cnt_val + 1'b1;
  end

  typedef struct {
    logic             start, stop, clr, periodic;
    logic [PSC_W-1:0] psc;
    logic [CNT_W-1:0] lim;
    logic             e_clr, e_ce, e_busy, e_done;
    logic [CNT_W-1:0] e_val;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic sp, input logic c, input logic p,
                              input int psc, input int lim, input logic ec, input logic ece,
                              input logic eb, input logic ed, input int ev);
    vec_t v;
    v.start = s; v.stop = sp; v.clr = c; v.periodic = p;
    v.psc = PSC_W'(psc); v.lim = CNT_W'(lim);
    v.e_clr = ec; v.e_ce = ece; v.e_busy = eb; v.e_done = ed; v.e_val = CNT_W'(ev);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven then, checks 1ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ec, input logic ece, input logic eb,
                          input logic ed);
    chk({tag, ".cnt_clr"}, 32'(cnt_clr), 32'(ec));
    chk({tag, ".cnt_ce"},  32'(cnt_ce),  32'(ece));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".done"},    32'(done),    32'(ed));
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; clr = tbl[i].clr;
      periodic = tbl[i].periodic; prescale = tbl[i].psc; limit = tbl[i].lim;
      #1;
      chk_outs($sformatf("%s[%0d]", tag, i), tbl[i].e_clr, tbl[i].e_ce, tbl[i].e_busy,
               tbl[i].e_done);
      chk($sformatf("%s[%0d].cnt_val", tag, i), 32'(cnt_val), 32'(tbl[i].e_val));
      nxt();
    end
    tbl.delete();
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b1; stop = 1'b0; clr = 1'b0; periodic = 1'b0;
    prescale = '0; limit = '0;
`ifdef CNTR_CTRL_IRQ_EN
    irq_ack = 1'b0;
`endif

    // Reset held 3 cycles with start high: nothing may happen.
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_outs($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CNTR_CTRL_IRQ_EN
      chk("rst.irq", 32'(irq), 32'd0);
`endif
    end
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk_outs("rel", 1'b0, 1'b0, 1'b0, 1'b0);
    nxt();

    // clr in IDLE, then one-shot prescale=1 limit=3. Mid-run limit/prescale change
    // and a stray start must be ignored.
    //            st sp cl pe psc lim  clr ce bsy dn val
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0));  // cycle 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   1, 0, 1, 0, 0));  // ARM
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 1, 1, 0, 0));  // cycle 3
    tbl.push_back(mk(1, 0, 0, 0, 0, 7,   0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 1, 1, 0, 1));  // cycle 5
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 1, 1, 0, 2));  // cycle 7
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 0, 1, 1, 3));  // cycle 8 done
    tbl.push_back(mk(0, 0, 0, 0, 0, 7,   0, 0, 0, 0, 3));  // cycle 9 idle
    run_tbl("oneshot");

    // Periodic prescale=0 limit=2: done every 4 cycles; stop on the third pass.
    tbl.push_back(mk(1, 0, 0, 1, 0, 2,   0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   1, 0, 1, 0, 3));  // ARM
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   1, 0, 1, 0, 2));  // ARM
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   1, 0, 1, 0, 2));  // ARM
    tbl.push_back(mk(0, 1, 0, 0, 0, 2,   0, 0, 1, 0, 0));  // stop in RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0));
    run_tbl("periodic");

    // Stop mid-run at cnt_val=5, prescale=0 limit=100.
    idle_in(); start = 1'b1; periodic = 1'b0; prescale = 8'd0; limit = 16'd100;
    nxt();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cnt_val == 16'd5 && busy) begin
        found = 1'b1;
        break;
      end
      nxt();
    end
    chk("stop.reach5", 32'(found), 32'd1);
    stop = 1'b1;
    #1;
    chk_outs("stop.cyc", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    stop = 1'b0;
    #1;
    chk_outs("stop.after", 1'b0, 1'b0, 1'b0, 1'b0);
    nxt(); nxt();
    chk("stop.hold", 32'(cnt_val), 32'd5);

    // stop together with match: no done.
    idle_in(); start = 1'b1; prescale = 8'd0; limit = 16'd2;
    nxt(); start = 1'b0; limit = 16'd9;
    nxt(); nxt(); nxt();
    chk("stopm.val", 32'(cnt_val), 32'd2);
    stop = 1'b1;
    #1;
    chk_outs("stopm", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt(); stop = 1'b0;
    #1;
    chk("stopm.busy", 32'(busy), 32'd0);

    // clr together with match: clear, no done, count restarts from 0.
    idle_in(); start = 1'b1; prescale = 8'd0; limit = 16'd2;
    nxt(); start = 1'b0;
    nxt(); nxt(); nxt();
    clr = 1'b1;
    #1;
    chk_outs("clrm", 1'b1, 1'b0, 1'b1, 1'b0);
    nxt(); clr = 1'b0;
    #1;
    chk("clrm.val0", 32'(cnt_val), 32'd0);
    chk_outs("clrm.rst", 1'b0, 1'b1, 1'b1, 1'b0);
    nxt(); nxt();
    chk_outs("clrm.done", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clrm.val2", 32'(cnt_val), 32'd2);
    nxt();
    chk("clrm.idle", 32'(busy), 32'd0);

    // start+stop in IDLE with limit=0: start taken, done on first RUN cycle.
    idle_in(); start = 1'b1; stop = 1'b1; prescale = 8'd0; limit = 16'd0;
    nxt(); idle_in();
    #1;
    chk_outs("lim0.arm", 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();
    chk_outs("lim0.run", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lim0.val", 32'(cnt_val), 32'd0);
    nxt();
    chk("lim0.idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-run: outputs drop at once, counter holds.
    idle_in(); start = 1'b1; prescale = 8'd0; limit = 16'd100;
    nxt(); start = 1'b0;
    nxt(); nxt();
    chk("arst.val", 32'(cnt_val), 32'd1);
    rst = 1'b0;
    #1;
    chk_outs("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    nxt();
    chk("arst.hold", 32'(cnt_val), 32'd1);
    rst = 1'b1;
    nxt();
    chk("arst.idle", 32'(busy), 32'd0);

`ifdef CNTR_CTRL_IRQ_EN
    // Periodic limit=0: done every 2 cycles; ack coinciding with done loses.
    idle_in(); start = 1'b1; periodic = 1'b1; prescale = 8'd0; limit = 16'd0;
    nxt(); start = 1'b0;
    nxt();
    chk("irq.done", 32'(done), 32'd1);
    chk("irq.pre", 32'(irq), 32'd0);
    nxt();
    chk("irq.set", 32'(irq), 32'd1);
    nxt(); irq_ack = 1'b1;
    #1;
    chk("irq.done2", 32'(done), 32'd1);
    nxt();
    chk("irq.setwins", 32'(irq), 32'd1);
    nxt(); irq_ack = 1'b0;
    chk("irq.clr", 32'(irq), 32'd0);
    stop = 1'b1;
    nxt(); stop = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
